// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module  : key_pkg
// Purpose : Shared state encoding, default timing constants and counter-width
//           helper for the push-button debounce / auto-repeat block.
// Revision: 1.0 - initial release
// ============================================================================
package key_pkg;

  // Press-tracking FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HELD   = 2'b01,
    REPEAT = 2'b10
  } key_state_t;

  // Defaults assume a 50 MHz clock
  localparam int DEB_CYCLES_DEFAULT    = 1000000;   // 20 ms
  localparam int REPEAT_DELAY_DEFAULT  = 25000000;  // 500 ms
  localparam int REPEAT_PERIOD_DEFAULT = 10000000;  // 200 ms

  // Bits needed to hold (largest of the three limits) - 1; at least one bit
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchroniser bringing an asynchronous level into clk.
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Two-stage capture; reset clears both stages so no stale press survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_pulse
// Purpose : Debounces a raw push-button and produces a one-cycle strobe on
//           each accepted press, plus optional auto-repeat strobes while the
//           button stays held.
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  input  logic rep_en,
  output logic level,
  output logic pulse,
  output logic held
);

  localparam int CW = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  logic          pb_sync;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] deb_cnt_nxt;
  logic          level_nxt;
  logic          rise;
  logic          fall;

  key_state_t    state;
  key_state_t    state_nxt;
  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] rep_cnt_nxt;
  logic          pulse_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pb_in),
    .q   (pb_sync)
  );

  // Debounce decision: count consecutive mismatches, accept on the last one
  always_comb begin
    level_nxt   = level;
    deb_cnt_nxt = '0;
    if (pb_sync != level) begin
      if (deb_cnt == DEB_LAST) begin
        level_nxt = pb_sync;
      end else begin
        deb_cnt_nxt = deb_cnt + CW'(1);
      end
    end
  end

  // Edge flags act on the same clock edge that updates level
  assign rise = level_nxt & ~level;
  assign fall = level & ~level_nxt;

  // Debounced level and its mismatch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      level   <= level_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  // Press FSM: next state, shared repeat counter and strobe request
  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    pulse_nxt   = 1'b0;
    case (state)
      IDLE: begin
        rep_cnt_nxt = '0;
        if (rise) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_nxt   = IDLE;
          rep_cnt_nxt = '0;
        end else if (rep_cnt == RD_LAST) begin
          // Saturates here until auto-repeat is enabled
          if (rep_en) begin
            state_nxt   = REPEAT;
            rep_cnt_nxt = '0;
            pulse_nxt   = 1'b1;
          end
        end else begin
          rep_cnt_nxt = rep_cnt + CW'(1);
        end
      end
      REPEAT: begin
        // A release beats a repeat strobe due on the same edge
        if (fall) begin
          state_nxt   = IDLE;
          rep_cnt_nxt = '0;
        end else if (!rep_en) begin
          state_nxt   = HELD;
          rep_cnt_nxt = RD_LAST;
        end else if (rep_cnt == RP_LAST) begin
          rep_cnt_nxt = '0;
          pulse_nxt   = 1'b1;
        end else begin
          rep_cnt_nxt = rep_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        rep_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, repeat counter and registered strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rep_cnt <= '0;
      pulse   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rep_cnt <= rep_cnt_nxt;
      pulse   <= pulse_nxt;
    end
  end

  assign held = (state == REPEAT);

endmodule : key_debounce_pulse
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_debounce_pulse
// Purpose : Self-checking bench for key_debounce_pulse (DEB=4, RD=20, RP=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_debounce_pulse;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk;
  logic rst;
  logic pb_in;
  logic rep_en;
  logic level;
  logic pulse;
  logic held;

  int compared;
  int mismatched;

  key_debounce_pulse #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pb_in  (pb_in),
    .rep_en (rep_en),
    .level  (level),
    .pulse  (pulse),
    .held   (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 3-state mode selector driven by the strobe
  logic [1:0] sel_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_out <= 2'b00;
    else if (pulse) sel_out <= (sel_out == 2'b10) ? 2'b00 : sel_out + 2'b01;
  end

  // ---------------- reference model (behavioural) ----------------
  bit m_s1, m_s2, m_level, m_pulse, m_active, m_rep;
  int m_since;        // edges since press or last strobe (unbounded)
  bit hist[$];        // last DEB synchronised samples
  bit prev_pulse;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0;
    m_active = 0; m_rep = 0; m_since = 0;
    hist.delete();
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled
  task automatic model_step();
    bit ps, nl, all_diff, rise, fall;
    if (rst) begin
      model_reset();
      return;
    end
    ps   = m_s2;
    m_s2 = m_s1;
    m_s1 = pb_in;
    hist.push_back(ps);
    if (hist.size() > DEB) void'(hist.pop_front());
    nl = m_level;
    if (hist.size() == DEB) begin
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
      if (all_diff) nl = !m_level;
    end
    rise    = !m_level && nl;
    fall    = m_level && !nl;
    m_pulse = 0;
    if (rise) begin
      m_active = 1; m_rep = 0; m_since = 0; m_pulse = 1;
    end else if (m_active) begin
      if (fall) begin
        m_active = 0; m_rep = 0;
      end else begin
        m_since++;
        if (!m_rep) begin
          if (rep_en && m_since >= RD) begin
            m_pulse = 1; m_rep = 1; m_since = 0;
          end
        end else if (!rep_en) begin
          m_rep = 0; m_since = RD;   // delay already elapsed
        end else if (m_since >= RP) begin
          m_pulse = 1; m_since = 0;
        end
      end
    end
    m_level = nl;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: step model, let the edge happen, compare just after it
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("outputs{level,pulse,held}", int'({level, pulse, held}),
        int'({m_level, m_pulse, m_rep}));
    if (prev_pulse) chk("pulse_back_to_back", int'(pulse), 0);
    prev_pulse = pulse;
  endtask

  task automatic idle_ticks(input int n);
    pb_in = 0;
    rep_en = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit pb;
    bit rep;
    int cycles;
    int exp_pulses;
    bit exp_level;
    bit exp_held;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vec_t v;
    int   np, rise_t, held_t, fall_t, t_first, lvl_seen, fall_pulse, fall_held;
    int   pq[$];
    int   exp_off[6];
    int   exp_sel[3];

    compared = 0; mismatched = 0; prev_pulse = 0;
    exp_off = '{0, 20, 28, 36, 44, 52};
    exp_sel = '{1, 2, 0};

    // Segments applied back to back from idle
    vecs[0] = '{pb:0, rep:0, cycles:10, exp_pulses:0, exp_level:0, exp_held:0};
    vecs[1] = '{pb:1, rep:0, cycles:3,  exp_pulses:0, exp_level:0, exp_held:0}; // too short
    vecs[2] = '{pb:0, rep:0, cycles:10, exp_pulses:0, exp_level:0, exp_held:0};
    vecs[3] = '{pb:1, rep:0, cycles:40, exp_pulses:1, exp_level:1, exp_held:0}; // no repeat
    vecs[4] = '{pb:0, rep:0, cycles:10, exp_pulses:0, exp_level:0, exp_held:0};
    vecs[5] = '{pb:1, rep:1, cycles:30, exp_pulses:2, exp_level:1, exp_held:1}; // press + first repeat
    vecs[6] = '{pb:1, rep:0, cycles:5,  exp_pulses:0, exp_level:1, exp_held:0}; // back to HELD
    vecs[7] = '{pb:1, rep:1, cycles:3,  exp_pulses:1, exp_level:1, exp_held:1}; // saturated -> immediate
    vecs[8] = '{pb:0, rep:1, cycles:10, exp_pulses:0, exp_level:0, exp_held:0}; // fall on due strobe
    vecs[9] = '{pb:0, rep:0, cycles:5,  exp_pulses:0, exp_level:0, exp_held:0};

    // Reset
    rst = 1; pb_in = 0; rep_en = 0;
    model_reset();
    #1;
    chk("reset_outputs", int'({level, pulse, held}), 0);
    tick(); tick();
    rst = 0;

    // Table-driven segments
    for (int k = 0; k < 10; k++) begin
      v = vecs[k];
      pb_in = v.pb; rep_en = v.rep; np = 0;
      for (int c = 0; c < v.cycles; c++) begin
        tick();
        if (pulse) np++;
      end
      chk($sformatf("vec%0d_pulses", k), np, v.exp_pulses);
      chk($sformatf("vec%0d_level", k), int'(level), int'(v.exp_level));
      chk($sformatf("vec%0d_held", k), int'(held), int'(v.exp_held));
    end

    // Clean press: level/pulse 5 edges after the first sampling edge (tick 1)
    idle_ticks(12);
    pb_in = 1; rise_t = -1; np = 0; held_t = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (level && rise_t < 0) rise_t = t;
      if (pulse) np++;
      if (held) held_t = 1;
    end
    chk("clean_rise_tick", rise_t, 6);
    chk("clean_pulse_count", np, 1);
    chk("clean_held_seen", held_t, 0);

    // Bounce every 2 cycles for 12 cycles, then stable high
    idle_ticks(12);
    lvl_seen = 0;
    for (int i = 0; i < 12; i++) begin
      pb_in = ((i / 2) % 2 == 0);
      tick();
      if (level) lvl_seen = 1;
    end
    chk("bounce_level_seen", lvl_seen, 0);
    pb_in = 1; t_first = -1; np = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (pulse) begin
        np++;
        if (t_first < 0) t_first = t;
      end
    end
    chk("bounce_pulse_tick", t_first, 6);
    chk("bounce_pulse_count", np, 1);

    // Auto-repeat over a 60-cycle hold, then release colliding with a strobe
    idle_ticks(12);
    rep_en = 1; pb_in = 1; held_t = -1;
    pq.delete();
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (pulse) pq.push_back(t);
      if (held && held_t < 0) held_t = t;
    end
    chk("repeat_pulse_count", pq.size(), 6);
    if (pq.size() > 0) begin
      chk("repeat_press_tick", pq[0], 6);
      chk("repeat_held_tick", held_t, pq[0] + 20);
      for (int i = 1; i < 6; i++)
        if (i < pq.size()) chk($sformatf("repeat_offset%0d", i), pq[i] - pq[0], exp_off[i]);
    end
    pb_in = 0; np = 0; fall_t = -1; fall_pulse = 0; fall_held = 0;
    for (int t = 61; t <= 80; t++) begin
      tick();
      if (pulse) np++;
      if (!level && fall_t < 0) begin
        fall_t = t; fall_pulse = pulse; fall_held = held;
      end
    end
    chk("collision_fall_tick", fall_t, 66);
    chk("collision_pulse", fall_pulse, 0);
    chk("collision_held", fall_held, 0);
    chk("collision_pulses_after", np, 0);

    // Reset during REPEAT with button still high
    idle_ticks(12);
    rep_en = 1; pb_in = 1;
    for (int t = 0; t < 30; t++) tick();
    chk("pre_reset_held", int'(held), 1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_reset_outputs", int'({level, pulse, held}), 0);
    tick(); tick();
    rst = 0; t_first = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (pulse && t_first < 0) t_first = t;
    end
    chk("post_reset_pulse_tick", t_first, 6);

    // Downstream mode chain: three clean presses
    rst = 1; tick(); rst = 0;
    chk("sel_initial", int'(sel_out), 0);
    rep_en = 0;
    for (int k = 0; k < 3; k++) begin
      pb_in = 1;
      for (int t = 0; t < 15; t++) tick();
      idle_ticks(12);
      chk($sformatf("sel_after_press%0d", k), int'(sel_out), exp_sel[k]);
    end

    // Randomised segments with bouncing, rep_en changes and rare resets
    for (int s = 0; s < 150; s++) begin
      int len;
      bit bouncy;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 30);
      bouncy = ($urandom_range(0, 2) == 0);
      pb_in = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) rep_en = ~rep_en;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; tick(); rst = 0;
      end
      for (int c = 0; c < len; c++) begin
        if (bouncy) pb_in = $urandom_range(0, 1);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Bound the whole run
  initial begin
    #2000000;
    mismatched++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_key_debounce_pulse
`default_nettype wire
